// File: rtl/fft_inpl_bfly_seq.sv
// ---------------------------------------------------------------------------
// fft_inpl_bfly_seq
//
// Address/control sequencer for an in-place radix-2 FFT. The butterfly
// datapath is not part of this block. One START runs LOGPTS stages. Each
// stage reads HALFPTS butterfly pairs, then waits RW_DLY cycles so that the
// butterfly pipeline can write back before the next stage starts reading.
//
// Optional feature: define FFT_INPL_SEQ_HOLD_EN to add hold_i. While the
// sequencer is reading, hold_i stalls the read counter for one cycle and
// suppresses that cycle's read.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        single-cycle request for one full pass (used only when idle)
//   hold_i         read stall (only with FFT_INPL_SEQ_HOLD_EN)
//   busy_o         pass in progress, up to and including the done cycle
//   done_o         one-cycle pulse after the final write of the final stage
//   ra_o           RAM read address (both banks)
//   ta_o           twiddle LUT address
//   rd_valid_o     ra_o / ta_o / presw_cross_o valid
//   presw_cross_o  pre-butterfly switch select
//   wa_o           RAM write address
//   wen_even_o     even-bank write enable
//   wen_odd_o      odd-bank write enable
//   stage_o        current read stage
//   last_stage_o   reading or draining the final stage
// ---------------------------------------------------------------------------
module fft_inpl_bfly_seq #(
    parameter int unsigned LOGPTS = 8,
    parameter int unsigned RW_DLY = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
`ifdef FFT_INPL_SEQ_HOLD_EN
    input  logic                      hold_i,
`endif
    output logic                      busy_o,
    output logic                      done_o,
    output logic [LOGPTS-2:0]         ra_o,
    output logic [LOGPTS-2:0]         ta_o,
    output logic                      rd_valid_o,
    output logic                      presw_cross_o,
    output logic [LOGPTS-2:0]         wa_o,
    output logic                      wen_even_o,
    output logic                      wen_odd_o,
    output logic [$clog2(LOGPTS)-1:0] stage_o,
    output logic                      last_stage_o
);

    localparam int unsigned AW = LOGPTS - 1;
    localparam int unsigned SW = $clog2(LOGPTS);
    localparam int unsigned DW = $clog2(RW_DLY + 1);

    localparam logic [AW-1:0] KMax  = {AW{1'b1}};
    localparam logic [DW-1:0] DMax  = DW'(RW_DLY - 1);
    localparam logic [SW-1:0] SLast = SW'(LOGPTS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

    state_e        state_q;
    logic [AW-1:0] k_q;
    logic [SW-1:0] s_q;
    logic [DW-1:0] dcnt_q;

    logic          hold;
    logic          rd_valid;
    logic [AW-1:0] mask;

`ifdef FFT_INPL_SEQ_HOLD_EN
    assign hold = hold_i;
`else
    assign hold = 1'b0;
`endif

    // Sequencer: k counts butterflies within a stage, dcnt counts drain
    // cycles, and s is the stage. s advances only when a new stage starts
    // reading, so stage_o holds its value through the drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRead;
                        k_q     <= '0;
                        s_q     <= '0;
                    end
                end
                StRead: begin
                    if (!hold) begin
                        if (k_q == KMax) begin
                            state_q <= StDrain;
                            k_q     <= '0;
                            dcnt_q  <= '0;
                        end else begin
                            k_q <= k_q + AW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (dcnt_q == DMax) begin
                        if (s_q == SLast) begin
                            state_q <= StFin;
                        end else begin
                            state_q <= StRead;
                            s_q     <= s_q + SW'(1);
                            k_q     <= '0;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    s_q     <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The top s bits of k select butterflies whose inputs arrive swapped
    // between the banks.
    assign mask     = ~(KMax >> s_q);
    assign rd_valid = (state_q == StRead) && !hold;

    assign rd_valid_o    = rd_valid;
    assign ra_o          = rd_valid ? k_q : '0;
    assign ta_o          = rd_valid ? (k_q << s_q) : '0;
    assign presw_cross_o = rd_valid & (^(k_q & mask));
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StFin);
    assign stage_o       = s_q;
    assign last_stage_o  = ((state_q == StRead) || (state_q == StDrain)) && (s_q == SLast);

    // The write side mirrors the butterfly latency. It shifts on every cycle
    // regardless of FSM state, and reset flushes any reads still in flight.
    logic [RW_DLY-1:0] wv_q;
    logic [AW-1:0]     wa_q [RW_DLY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wv_q <= '0;
            for (int i = 0; i < RW_DLY; i++) begin
                wa_q[i] <= '0;
            end
        end else begin
            wv_q[0] <= rd_valid;
            wa_q[0] <= ra_o;
            for (int i = 1; i < RW_DLY; i++) begin
                wv_q[i] <= wv_q[i-1];
                wa_q[i] <= wa_q[i-1];
            end
        end
    end

    assign wa_o       = wa_q[RW_DLY-1];
    assign wen_even_o = wv_q[RW_DLY-1];
    assign wen_odd_o  = wv_q[RW_DLY-1];

endmodule
